// File: rtl/dm_cache_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_cache_controller_pkg
// Description : Shared widths, address-field positions and FSM states for the
//               direct-mapped write-back cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_cache_controller_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int INDEX_W  = 10;
    localparam int OFFSET_W = 2;
    localparam int IDX_LSB  = OFFSET_W;
    localparam int TAG_LSB  = INDEX_W + OFFSET_W;
    localparam int TAG_W    = ADDR_W - TAG_LSB;
    localparam int LINES    = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        WRITE     = 3'd2,
        WRITEBACK = 3'd3,
        WBWAIT    = 3'd4,
        MEMREQ    = 3'd5,
        MEMWAIT   = 3'd6,
        UPDATE    = 3'd7
    } state_t;

    // Memory byte address of a whole line (offset bits forced to zero).
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] idx);
        return {tag, idx, {OFFSET_W{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_cache_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_cache_controller_if
// Description : CPU-side and memory-side bus of the cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_cache_controller_if;
    import dm_cache_controller_pkg::*;

    logic [ADDR_W-1:0] CAddress;
    logic              CStrobe;
    logic              CRW;
    logic              CReady;
    logic [DATA_W-1:0] CData_In;
    logic [DATA_W-1:0] CData_Out;
    logic [ADDR_W-1:0] MAddress;
    logic              MStrobe;
    logic              MRW;
    logic [DATA_W-1:0] MData_In;
    logic [DATA_W-1:0] MData_Out;
    logic              MReady;

    modport slave (
        input  CAddress, CStrobe, CRW, CData_In, MData_In, MReady,
        output CReady, CData_Out, MAddress, MStrobe, MRW, MData_Out
    );

    modport master (
        output CAddress, CStrobe, CRW, CData_In, MData_In, MReady,
        input  CReady, CData_Out, MAddress, MStrobe, MRW, MData_Out
    );
endinterface
`default_nettype wire

// File: rtl/dm_cache_array.sv
`default_nettype none
// ============================================================================
// Module      : dm_cache_array
// Description : Tag/valid/dirty/data storage, one combinational read port and
//               one synchronous write port. Reset clears valid and dirty only.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_cache_array
    import dm_cache_controller_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [INDEX_W-1:0] i_rd_idx,
    output logic                    o_rd_valid,
    output logic                    o_rd_dirty,
    output logic [TAG_W-1:0]        o_rd_tag,
    output logic [DATA_W-1:0]       o_rd_data,
    input  wire logic               i_we,
    input  wire logic [INDEX_W-1:0] i_wr_idx,
    input  wire logic [TAG_W-1:0]   i_wr_tag,
    input  wire logic [DATA_W-1:0]  i_wr_data,
    input  wire logic               i_wr_dirty
);
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    // Every write installs a line, so it always leaves the line valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
            r_dirty[i_wr_idx] <= i_wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];
endmodule
`default_nettype wire

// File: rtl/dm_cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dm_cache_controller
// Description : Direct-mapped, one-word-per-line, write-back/write-allocate
//               cache controller between a CPU port and a slow memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_cache_controller
    import dm_cache_controller_pkg::*;
(
    input wire logic              clk,
    input wire logic              reset,
    dm_cache_controller_if.slave  bus
);
    state_t             r_state;
    logic [TAG_W-1:0]   r_tag;
    logic [INDEX_W-1:0] r_idx;
    logic               r_rw;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_fill;
    logic [DATA_W-1:0]  r_cdata;
    logic [DATA_W-1:0]  r_mdata;
    logic               r_cready;
    logic               r_mstrobe;
    logic               r_mrw;
    logic [ADDR_W-1:0]  r_maddr;

    logic [TAG_W-1:0]   w_req_tag;
    logic [INDEX_W-1:0] w_req_idx;
    logic [INDEX_W-1:0] w_rd_idx;
    logic               w_rd_valid;
    logic               w_rd_dirty;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_hit;
    logic               w_we;
    logic               w_unused_offset;

    assign w_req_tag       = bus.CAddress[ADDR_W-1:TAG_LSB];
    assign w_req_idx       = bus.CAddress[TAG_LSB-1:IDX_LSB];
    assign w_unused_offset = ^bus.CAddress[IDX_LSB-1:0];

    // Lookup uses the live CPU address in IDLE, the latched one afterwards.
    assign w_rd_idx = (r_state == IDLE) ? w_req_idx : r_idx;
    assign w_hit    = w_rd_valid && (w_rd_tag == w_req_tag);
    assign w_we     = (r_state == WRITE) || (r_state == UPDATE);

    dm_cache_array u_array (
        .clk        (clk),
        .reset      (reset),
        .i_rd_idx   (w_rd_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_dirty (w_rd_dirty),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_we),
        .i_wr_idx   (r_idx),
        .i_wr_tag   (r_tag),
        .i_wr_data  ((r_state == UPDATE) ? r_fill : r_wdata),
        .i_wr_dirty (r_state == WRITE)
    );

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cready  <= 1'b0;
            r_mstrobe <= 1'b0;
            r_mrw     <= 1'b1;
            r_maddr   <= '0;
            r_tag     <= '0;
            r_idx     <= '0;
            r_rw      <= 1'b1;
            r_wdata   <= '0;
            r_fill    <= '0;
            r_cdata   <= '0;
            r_mdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.CStrobe) begin
                        r_tag   <= w_req_tag;
                        r_idx   <= w_req_idx;
                        r_rw    <= bus.CRW;
                        r_wdata <= bus.CData_In;
                        if (w_hit) begin
                            r_cready <= 1'b1;
                            r_cdata  <= w_rd_data;
                            r_state  <= bus.CRW ? READ : WRITE;
                        end else if (w_rd_valid && w_rd_dirty) begin
                            r_maddr   <= line_addr(w_rd_tag, w_req_idx);
                            r_mrw     <= 1'b0;
                            r_mstrobe <= 1'b1;
                            r_mdata   <= w_rd_data;
                            r_state   <= WRITEBACK;
                        end else begin
                            r_maddr   <= line_addr(w_req_tag, w_req_idx);
                            r_mrw     <= 1'b1;
                            r_mstrobe <= 1'b1;
                            r_state   <= MEMREQ;
                        end
                    end
                end
                READ, WRITE: begin
                    r_cready <= 1'b0;
                    r_state  <= IDLE;
                end
                WRITEBACK: begin
                    r_mstrobe <= 1'b0;
                    r_state   <= WBWAIT;
                end
                WBWAIT: begin
                    if (bus.MReady) begin
                        r_maddr   <= line_addr(r_tag, r_idx);
                        r_mrw     <= 1'b1;
                        r_mstrobe <= 1'b1;
                        r_state   <= MEMREQ;
                    end
                end
                MEMREQ: begin
                    r_mstrobe <= 1'b0;
                    r_state   <= MEMWAIT;
                end
                MEMWAIT: begin
                    if (bus.MReady) begin
                        r_fill  <= bus.MData_In;
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_cready <= 1'b1;
                    r_cdata  <= r_fill;
                    r_state  <= r_rw ? READ : WRITE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.CReady    = r_cready;
    assign bus.MStrobe   = r_mstrobe;
    assign bus.MRW       = r_mrw;
    assign bus.MAddress  = r_maddr;
    assign bus.CData_Out = (r_state == READ) ? r_cdata : 'z;
    assign bus.MData_Out = ((r_state == WRITEBACK) || (r_state == WBWAIT)) ? r_mdata : 'z;
endmodule
`default_nettype wire

// File: tb/tb_dm_cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_cache_controller
// Description : Directed bench with a simple word memory model for the cache.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_cache_controller;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    dm_cache_controller_if bus ();

    dm_cache_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Word memory: a strobe with MRW=1 returns data next cycle, MRW=0 stores.
    logic [31:0] mem [logic [31:0]];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;

    always @(posedge clk) begin
        if (bus.MStrobe) begin
            if (bus.MRW) begin
                bus.MData_In <= mem.exists(bus.MAddress) ? mem[bus.MAddress] : 32'h0;
                rd_cnt       = rd_cnt + 1;
                last_rd_addr = bus.MAddress;
            end else begin
                mem[bus.MAddress] = bus.MData_Out;
                wr_cnt       = wr_cnt + 1;
                last_wr_addr = bus.MAddress;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one CPU request; lat counts cycles from the IDLE cycle to CReady.
    task automatic cpu_op(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
        @(negedge clk);
        bus.CAddress = addr;
        bus.CRW      = rw;
        bus.CData_In = wdata;
        bus.CStrobe  = 1'b1;
        lat   = -1;
        rdata = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.CReady) begin
                lat   = i + 1;
                rdata = bus.CData_Out;
                break;
            end
        end
        bus.CStrobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;

        mem[32'h0]    = 32'h23;
        mem[32'h4]    = 32'h7;
        mem[32'h8]    = 32'h15;
        mem[32'h1000] = 32'h2;
        bus.MReady    = 1'b1;
        bus.CStrobe   = 1'b0;
        bus.CRW       = 1'b1;
        bus.CAddress  = '0;
        bus.CData_In  = '0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cready",  {31'b0, bus.CReady},  32'd0);
        chk("rst_mstrobe", {31'b0, bus.MStrobe}, 32'd0);
        chk("rst_mrw",     {31'b0, bus.MRW},     32'd1);
        chk("rst_maddr",   bus.MAddress,         32'h0);
        reset = 1'b0;

        // Cold read misses on clean lines
        cpu_op(1'b1, 32'h0, 32'h0, rd, lat);
        chk("miss0_data", rd, 32'h23);
        chk("miss0_lat", lat, 32'd5);
        chk("miss0_maddr", last_rd_addr, 32'h0);
        cpu_op(1'b1, 32'h4, 32'h0, rd, lat);
        chk("miss4_data", rd, 32'h7);
        cpu_op(1'b1, 32'h8, 32'h0, rd, lat);
        chk("miss8_data", rd, 32'h15);
        chk("miss_rdcnt", rd_cnt, 32'd3);

        // Read hits: no memory traffic, two-cycle latency
        cpu_op(1'b1, 32'h0, 32'h0, rd, lat);
        chk("hit0_data", rd, 32'h23);
        chk("hit0_lat", lat, 32'd2);
        cpu_op(1'b1, 32'h4, 32'h0, rd, lat);
        chk("hit4_data", rd, 32'h7);
        cpu_op(1'b1, 32'h8, 32'h0, rd, lat);
        chk("hit8_data", rd, 32'h15);
        chk("hit_rdcnt", rd_cnt, 32'd3);

        // Write hits stay in the cache
        cpu_op(1'b0, 32'h0, 32'd598, rd, lat);
        chk("wr0_lat", lat, 32'd2);
        cpu_op(1'b0, 32'h4, 32'd65, rd, lat);
        cpu_op(1'b0, 32'h8, 32'd100, rd, lat);
        chk("wrhit_wrcnt", wr_cnt, 32'd0);
        chk("wrhit_rdcnt", rd_cnt, 32'd3);
        chk("wrhit_mem0", mem[32'h0], 32'h23);
        cpu_op(1'b1, 32'h0, 32'h0, rd, lat);
        chk("rb0_data", rd, 32'd598);
        cpu_op(1'b1, 32'h4, 32'h0, rd, lat);
        chk("rb4_data", rd, 32'd65);
        cpu_op(1'b1, 32'h8, 32'h0, rd, lat);
        chk("rb8_data", rd, 32'd100);

        // Write miss on dirty line 0: write back, then allocate
        cpu_op(1'b0, 32'h1000, 32'd253, rd, lat);
        chk("wmiss_lat", lat, 32'd7);
        chk("wmiss_wrcnt", wr_cnt, 32'd1);
        chk("wmiss_wraddr", last_wr_addr, 32'h0);
        chk("wmiss_mem0", mem[32'h0], 32'd598);
        chk("wmiss_rdcnt", rd_cnt, 32'd4);
        chk("wmiss_rdaddr", last_rd_addr, 32'h1000);
        cpu_op(1'b1, 32'h1000, 32'h0, rd, lat);
        chk("r1000_data", rd, 32'd253);
        chk("r1000_lat", lat, 32'd2);
        chk("r1000_mem", mem[32'h1000], 32'h2);

        // Read miss evicting dirty 0x1000 line
        cpu_op(1'b1, 32'h0, 32'h0, rd, lat);
        chk("evict_data", rd, 32'd598);
        chk("evict_lat", lat, 32'd7);
        chk("evict_mem1000", mem[32'h1000], 32'd253);
        chk("evict_wrcnt", wr_cnt, 32'd2);

        // Reset while waiting on memory aborts the miss
        @(negedge clk);
        bus.CAddress = 32'h2000;
        bus.CRW      = 1'b1;
        bus.CStrobe  = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_maddr_pre", bus.MAddress, 32'h2000);
        bus.CStrobe = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        chk("abort_cready",  {31'b0, bus.CReady},  32'd0);
        chk("abort_mstrobe", {31'b0, bus.MStrobe}, 32'd0);
        chk("abort_mrw",     {31'b0, bus.MRW},     32'd1);
        chk("abort_maddr",   bus.MAddress,         32'h0);
        reset = 1'b0;

        // Lines are invalid afterwards: line 4 refetches from memory
        cpu_op(1'b1, 32'h4, 32'h0, rd, lat);
        chk("post_rst4_data", rd, 32'h7);
        chk("post_rst4_lat", lat, 32'd5);
        cpu_op(1'b1, 32'h0, 32'h0, rd, lat);
        chk("post_rst0_data", rd, 32'd598);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
